// File: rtl/instr_issuer.sv
// rtl/instr_issuer.sv - start/wait handshake initiator that fetches and issues instructions to the controller
//
// Walks a program counter from address 0 to end_addr (inclusive, wrapping modulo
// 2^ADDR_W). Each word is latched and its opcode is checked. A legal word is issued
// to the controller by a one-cycle s pulse once the controller reports WAIT (w=1).
// The issuer then waits for w to return high before it moves to the next address.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   go         in   start program at address 0 (honoured only in IDLE/DONE)
//   end_addr   in   address of the last instruction (inclusive)
//   mem_addr   out  registered instruction memory address
//   mem_rdata  in   memory read data, valid one cycle after mem_addr
//   w          in   controller idle flag (1 = controller in WAIT)
//   s          out  one-cycle start pulse to the controller
//   opcode     out  instr[15:13]
//   op         out  instr[12:11]
//   instr      out  latched instruction word
//   busy       out  high in every state except IDLE/DONE
//   done       out  high in DONE
//   err        out  00 ok, 01 illegal opcode, 10 timeout (sticky until go/reset)
//   issued     out  saturating count of s pulses
module instr_issuer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              w,
    output logic              s,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [15:0]       instr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [15:0]       issued
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        WAIT_W,
        ISSUE,
        EXEC,
        NEXT,
        DONE
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;

    // The controller re-reads op mid-execution, so these are taken from the
    // latched word, which only changes in LATCH.
    assign opcode = instr[15:13];
    assign op     = instr[12:11];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            s        <= 1'b0;
            mem_addr <= '0;
            instr    <= 16'h0000;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= ERR_OK;
            issued   <= 16'h0000;
            timer    <= '0;
        end else begin
            // s is high only for the single cycle spent in ISSUE.
            s <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state    <= FETCH;
                        mem_addr <= '0;
                        err      <= ERR_OK;
                        issued   <= 16'h0000;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    instr <= mem_rdata;
                    // The controller hangs in DECODE on unknown opcodes, so only
                    // 110 and 101 may ever reach it.
                    if (mem_rdata[15:13] == 3'b110 || mem_rdata[15:13] == 3'b101) begin
                        state <= WAIT_W;
                    end else begin
                        state <= DONE;
                        err   <= ERR_ILLEGAL;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                WAIT_W: begin
                    if (w) begin
                        state <= ISSUE;
                        s     <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issued != 16'hFFFF) begin
                        issued <= issued + 16'd1;
                    end
                    timer <= '0;
                    state <= EXEC;
                end
                EXEC: begin
                    timer <= timer + 1'b1;
                    if (w) begin
                        state <= NEXT;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state <= DONE;
                        err   <= ERR_TIMEOUT;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                NEXT: begin
                    if (mem_addr == end_addr) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issuer.sv
// tb/tb_instr_issuer.sv - self-checking bench for instr_issuer
module tb_instr_issuer;

    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [7:0]  end_addr;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        w;
    logic        s;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [15:0] instr;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [15:0] issued;

    instr_issuer #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .end_addr (end_addr),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .w        (w),
        .s        (s),
        .opcode   (opcode),
        .op       (op),
        .instr    (instr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .issued   (issued)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Synchronous-read instruction memory.
    logic [15:0] mem [256];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    // Controller model: leaves WAIT as soon as it sees s, comes back after ctl_len cycles.
    bit ctl_auto;
    bit ctl_hang;
    int ctl_len;
    int ctl_cnt;
    always begin
        @(negedge clk);
        #1;
        if (ctl_auto && !reset) begin
            if (s) begin
                w = 1'b0;
                ctl_cnt = ctl_len;
            end else if (!w && !ctl_hang) begin
                if (ctl_cnt <= 1) w = 1'b1;
                else ctl_cnt--;
            end
        end
    end

    // Monitor: record issued words, check pulse shape and stability while the controller runs.
    logic [15:0] got_q[$];
    logic [15:0] lock;
    bit          watching;
    bit          prev_s;
    always @(negedge clk) begin
        if (reset) begin
            watching = 1'b0;
            prev_s   = 1'b0;
        end else begin
            if (s) begin
                check("s_one_cycle", 32'(prev_s), 32'd0);
                check("s_needs_w", 32'(w), 32'd1);
                got_q.push_back(instr);
                lock     = instr;
                watching = 1'b1;
            end else if (watching) begin
                if (w) watching = 1'b0;
                else check("stable_while_w0", 32'({opcode, op, instr}), 32'({lock[15:11], lock}));
            end
            prev_s = s;
        end
    end

    // Reference model: walk the program by address, stop on illegal word, hang or end_addr.
    logic [15:0] exp_q[$];
    function automatic bit legal(input logic [15:0] word);
        return (word[15:13] == 3'b110) || (word[15:13] == 3'b101);
    endfunction

    function automatic void ref_run(input logic [7:0] ea, input bit hang,
                                    output logic [1:0] e, output logic [7:0] fa);
        logic [7:0] a;
        a = 8'd0;
        e = 2'b00;
        exp_q.delete();
        for (int n = 0; n < 300; n++) begin
            if (!legal(mem[a])) begin
                e = 2'b01;
                break;
            end
            exp_q.push_back(mem[a]);
            if (hang) begin
                e = 2'b10;
                break;
            end
            if (a == ea) break;
            a = a + 8'd1;
        end
        fa = a;
    endfunction

    task automatic do_reset(input bit check_state);
        reset    = 1'b1;
        go       = 1'b0;
        w        = 1'b1;
        ctl_auto = 1'b1;
        ctl_hang = 1'b0;
        ctl_cnt  = 0;
        watching = 1'b0;
        got_q.delete();
        repeat (2) @(negedge clk);
        if (check_state)
            check("reset_state", 32'({s, mem_addr, instr, busy, done, err, issued}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_go(output bit ok);
        got_q.delete();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic restore_w();
        ctl_hang = 1'b0;
        w = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]       ea;
        logic [3:0][15:0] words;
        int               len;
        bit               hang;
        int               exp_n;
        logic [1:0]       exp_err;
        logic [7:0]       exp_addr;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic [7:0] ea, input logic [15:0] w0, w1, w2, w3,
                           input int len, input bit hang, input int exp_n,
                           input logic [1:0] exp_err, input logic [7:0] exp_addr);
        vec_t v;
        v.ea = ea;
        v.words = {w3, w2, w1, w0};
        v.len = len;
        v.hang = hang;
        v.exp_n = exp_n;
        v.exp_err = exp_err;
        v.exp_addr = exp_addr;
        vecs.push_back(v);
    endtask

    initial begin
        bit          ok;
        int          cnt;
        int          s_seen;
        logic [1:0]  e;
        logic [7:0]  fa;
        bit          match;

        foreach (mem[i]) mem[i] = 16'h0000;
        end_addr = 8'd0;
        ctl_len  = 2;
        do_reset(1'b1);

        // Table-driven programs.
        add_vec(8'd0, 16'hD007, 16'h0000, 16'h0000, 16'h0000, 2, 1'b0, 1, 2'b00, 8'd0);
        add_vec(8'd2, 16'hD007, 16'hD102, 16'hA028, 16'h0000, 3, 1'b0, 3, 2'b00, 8'd2);
        add_vec(8'd3, 16'hD007, 16'hE000, 16'hD007, 16'hD007, 2, 1'b0, 1, 2'b01, 8'd1);
        add_vec(8'd2, 16'hD007, 16'hD102, 16'hA028, 16'h0000, 2, 1'b1, 1, 2'b10, 8'd0);
        add_vec(8'd1, 16'hA000, 16'hC800, 16'h0000, 16'h0000, 1, 1'b0, 2, 2'b00, 8'd1);
        add_vec(8'd0, 16'h0000, 16'hD007, 16'h0000, 16'h0000, 1, 1'b0, 0, 2'b01, 8'd0);
        for (int k = 0; k < vecs.size(); k++) begin
            for (int i = 0; i < 4; i++) mem[i] = vecs[k].words[i];
            end_addr = vecs[k].ea;
            ctl_len  = vecs[k].len;
            ctl_hang = vecs[k].hang;
            run_go(ok);
            check($sformatf("vec%0d_done", k), 32'(ok), 32'd1);
            check($sformatf("vec%0d_issued", k), 32'(issued), 32'(vecs[k].exp_n));
            check($sformatf("vec%0d_err", k), 32'(err), 32'(vecs[k].exp_err));
            check($sformatf("vec%0d_addr", k), 32'(mem_addr), 32'(vecs[k].exp_addr));
            check($sformatf("vec%0d_pulses", k), 32'(got_q.size()), 32'(vecs[k].exp_n));
            if (vecs[k].exp_n > 0 && got_q.size() > 0)
                check($sformatf("vec%0d_first_word", k), 32'(got_q[0]), 32'(vecs[k].words[0]));
            restore_w();
        end

        // go -> first s latency with w already high.
        do_reset(1'b0);
        mem[0] = 16'hD007;
        end_addr = 8'd0;
        ctl_len = 2;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("lat_busy", 32'(busy), 32'd1);
        s_seen = 0;
        for (int i = 0; i < 3; i++) begin
            s_seen += int'(s);
            @(negedge clk);
        end
        check("lat_s_early", 32'(s_seen), 32'd0);
        check("lat_s_at_4", 32'(s), 32'd1);
        @(negedge clk);
        check("lat_s_drop", 32'(s), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("lat_done", 32'({ok, err, issued}), 32'({1'b1, 2'b00, 16'd1}));

        // Timeout: EXEC runs TIMEOUT cycles (timer 0..TIMEOUT-1), DONE is seen one sample later.
        do_reset(1'b0);
        mem[0] = 16'hD007;
        end_addr = 8'd2;
        mem[1] = 16'hD102;
        ctl_hang = 1'b1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("to_first_s", 32'(ok), 32'd1);
        cnt = 0;
        s_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            s_seen += int'(s);
            if (done) break;
        end
        check("to_cycles", 32'(cnt), 32'(TIMEOUT + 1));
        check("to_err", 32'({done, err, issued}), 32'({1'b1, 2'b10, 16'd1}));
        check("to_no_second_s", 32'(s_seen), 32'd0);
        restore_w();

        // Controller busy at go: s waits in WAIT_W, then fires one cycle after w rises.
        do_reset(1'b0);
        mem[0] = 16'hD007;
        end_addr = 8'd0;
        ctl_auto = 1'b0;
        w = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        s_seen = 0;
        for (int i = 0; i < 10; i++) begin
            s_seen += int'(s);
            @(negedge clk);
        end
        check("busyw_no_s", 32'(s_seen), 32'd0);
        w = 1'b1;
        @(negedge clk);
        check("busyw_s_after_w", 32'(s), 32'd1);
        ctl_auto = 1'b1;
        ctl_len = 2;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("busyw_done", 32'({done, err, issued}), 32'({1'b1, 2'b00, 16'd1}));

        // Reset during EXEC, then go while busy in a fresh run.
        do_reset(1'b0);
        mem[0] = 16'hD007;
        mem[1] = 16'hD102;
        mem[2] = 16'hA028;
        end_addr = 8'd2;
        ctl_len = 6;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s) break;
            @(negedge clk);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_exec", 32'({s, busy, issued, err, done, mem_addr}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        watching = 1'b0;
        w = 1'b1;
        ctl_cnt = 0;
        @(negedge clk);
        got_q.delete();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s) break;
            @(negedge clk);
        end
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("go_busy_ignored", 32'({busy, mem_addr, issued}), 32'({1'b1, 8'd0, 16'd1}));
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("go_busy_final", 32'({done, err, issued, mem_addr}), 32'({1'b1, 2'b00, 16'd3, 8'd2}));

        // Randomised programs against the reference model.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 9; i++) begin
                logic [2:0] opc;
                if ($urandom_range(0, 99) < 85) opc = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b101;
                else begin
                    opc = 3'($urandom_range(0, 5));
                    if (opc >= 3'd5) opc = opc + 3'd2;
                end
                mem[i] = {opc, 13'($urandom)};
            end
            end_addr = 8'($urandom_range(0, 7));
            ctl_len  = int'($urandom_range(1, 4));
            ctl_hang = ($urandom_range(0, 7) == 0);
            ref_run(end_addr, ctl_hang, e, fa);
            run_go(ok);
            check($sformatf("rnd%0d_done", r), 32'(ok), 32'd1);
            check($sformatf("rnd%0d_err", r), 32'(err), 32'(e));
            check($sformatf("rnd%0d_issued", r), 32'(issued), 32'(exp_q.size()));
            check($sformatf("rnd%0d_addr", r), 32'(mem_addr), 32'(fa));
            match = (got_q.size() == exp_q.size());
            if (match) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) match = 1'b0;
            check($sformatf("rnd%0d_words", r), 32'(match), 32'd1);
            restore_w();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
